dfu_ar_arbiter: RTL and testbench
=================================

Name: dfu_ar_arbiter

Overview:
- Registered arbiter that shares the single DFU-to-AR request channel between the load path (DFU input side, AR writes) and the store path (DFU output side, AR reads).
- Grants the channel with round-robin priority and locks it to one owner for a whole transaction.
- Forwards only the owner's request, address and data signals, then inserts a one-cycle release gap.
- Replaces fixed-priority combinational muxing of the two paths' AR signals in the DFU top level.

Parameters:
FIFO_WIDTH, 32, width of the AR address field
DATA_WIDTH, 32, width of the AR data field
TIMEOUT_CYC, 1024, cycles in REQ without ar2dfu_grant before arb_timeout is set

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
ld_grant_req  input  1  load path requests the AR channel
ld_wr_req  input  1  load path request type
ld_addr  input  FIFO_WIDTH  load path address
ld_addr_vld  input  1  load path address valid
ld_data_out  input  DATA_WIDTH  load path data
ld_data_out_vld  input  1  load path data valid
ld_grant  output  1  load path owns the channel
st_grant_req  input  1  store path requests the AR channel
st_rd_req  input  1  store path request type
st_addr  input  FIFO_WIDTH  store path address
st_addr_vld  input  1  store path address valid
st_data_out  input  DATA_WIDTH  store path data
st_data_out_vld  input  1  store path data valid
st_grant  output  1  store path owns the channel
dfu2ar_grant_req  output  1  channel request to AR
ar2dfu_grant  input  1  AR grant
dfu2ar_wr_req  output  1  forwarded request type
dfu2ar_addr  output  FIFO_WIDTH  forwarded address
dfu2ar_addr_vld  output  1  forwarded address valid
dfu2ar_data_out  output  DATA_WIDTH  forwarded data
dfu2ar_data_out_vld  output  1  forwarded data valid
arb_owner  output  1  current or last selected owner: 0 = load, 1 = store
arb_busy  output  1  state is not IDLE
arb_timeout  output  1  sticky timeout flag

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high.
- On reset: state IDLE, last_owner = 1, arb_owner = 0, wait counter = 0. All outputs are 0.
- The FSM has four states: IDLE, REQ, OWN, GAP.
- IDLE:
  - If exactly one of ld_grant_req / st_grant_req is high, select that path.
  - If both are high, select the path that is not last_owner. Load therefore wins the first contention after reset.
  - Latch the selection into arb_owner and go to REQ on the next edge. Wait counter is cleared.
- REQ:
  - dfu2ar_grant_req = 1. All other dfu2ar_* outputs are 0. ld_grant and st_grant are 0.
  - Owner's grant_req low: go to IDLE. last_owner is unchanged and the request is abandoned.
  - Otherwise, ar2dfu_grant high: go to OWN.
  - Otherwise, increment the wait counter. The counter saturates and is $clog2(TIMEOUT_CYC+1) bits wide. When it reaches TIMEOUT_CYC, set arb_timeout; the FSM keeps waiting.
- OWN:
  - dfu2ar_grant_req = 1. The owner's grant output is 1.
  - The owner's wr/rd_req, addr, addr_vld, data_out and data_out_vld pass combinationally to dfu2ar_*. st_rd_req maps to dfu2ar_wr_req.
  - The non-owner's inputs are ignored and its grant output stays 0, even if it is requesting.
  - ar2dfu_grant is ignored while in OWN.
  - Owner drops grant_req: go to GAP and set last_owner = arb_owner.
- GAP: all dfu2ar_* outputs and both grants are 0 for exactly one cycle, then IDLE.
- Latency:
  - Request seen in IDLE at edge N: dfu2ar_grant_req is high from cycle N+1.
  - ar2dfu_grant seen at edge K: the owner's grant and forwarding are active from cycle K+1.
  - Release seen at edge M: outputs are 0 from M+1, and a new REQ is possible at M+3.
- A new request arriving in REQ, OWN or GAP waits and is evaluated in IDLE.
- arb_timeout clears only on rst.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and outputs drop asynchronously.
- arb_busy = 1 in REQ, OWN and GAP.

Test Plan:
1. Load-only transaction:
   - Stimulus: ld_grant_req=1 at cycle 2; ar2dfu_grant=1 at cycle 5; ld_addr=0x100, ld_addr_vld=1 at cycle 7; ld_grant_req=0 at cycle 9.
   - Required: dfu2ar_grant_req=1 cycles 3-9; ld_grant=1 cycles 6-9; dfu2ar_addr=0x100 at cycle 7; all outputs 0 at cycle 10; arb_busy=0 at cycle 11.
2. Simultaneous requests after reset:
   - Stimulus: both paths request at cycle 2.
   - Required: arb_owner=0 and load is served first. After load releases, store is granted with arb_owner=1. st_grant is 0 throughout the load transaction.
3. Round-robin:
   - Stimulus: after a completed store transaction, both paths request together.
   - Required: load wins. After a load transaction, both requesting: store wins.
4. Abandon:
   - Stimulus: st_grant_req drops while in REQ, before ar2dfu_grant.
   - Required: IDLE on the next edge; st_grant never asserted; last_owner unchanged (verified by a following contention).
5. Timeout:
   - Stimulus: TIMEOUT_CYC=8; a request is held with no ar2dfu_grant.
   - Required: arb_timeout=1 eight cycles after REQ entry. A later grant still reaches OWN. arb_timeout stays 1 until rst.
6. Reset mid-OWN:
   - Stimulus: rst pulse while load is forwarding data.
   - Required: all outputs 0 in the same cycle; state IDLE; the next contention goes to load.

Source files
------------

// File: rtl/dfu_ar_arbiter.sv
// dfu_ar_arbiter: round-robin owner arbitration of the shared DFU-to-AR
// request channel between the load path and the store path. A grant is
// locked to one owner for a whole transaction and is followed by a single
// idle cycle before the channel can be contended again.
module dfu_ar_arbiter #(
    parameter int FIFO_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ld_grant_req,
    input  logic                  ld_wr_req,
    input  logic [FIFO_WIDTH-1:0] ld_addr,
    input  logic                  ld_addr_vld,
    input  logic [DATA_WIDTH-1:0] ld_data_out,
    input  logic                  ld_data_out_vld,
    output logic                  ld_grant,

    input  logic                  st_grant_req,
    input  logic                  st_rd_req,
    input  logic [FIFO_WIDTH-1:0] st_addr,
    input  logic                  st_addr_vld,
    input  logic [DATA_WIDTH-1:0] st_data_out,
    input  logic                  st_data_out_vld,
    output logic                  st_grant,

    output logic                  dfu2ar_grant_req,
    input  logic                  ar2dfu_grant,
    output logic                  dfu2ar_wr_req,
    output logic [FIFO_WIDTH-1:0] dfu2ar_addr,
    output logic                  dfu2ar_addr_vld,
    output logic [DATA_WIDTH-1:0] dfu2ar_data_out,
    output logic                  dfu2ar_data_out_vld,

    output logic                  arb_owner,
    output logic                  arb_busy,
    output logic                  arb_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_OWN,
        S_GAP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last_owner;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             any_req;
    logic             sel_owner;
    logic             owner_req;

    assign any_req   = ld_grant_req | st_grant_req;
    // Under contention the path that did not complete the last transaction wins.
    assign sel_owner = (ld_grant_req && st_grant_req) ? ~last_owner : st_grant_req;
    assign owner_req = arb_owner ? st_grant_req : ld_grant_req;
    assign cnt_inc   = wait_cnt + CNT_W'(1);
    assign arb_busy  = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision; an abandoned request returns straight to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (!owner_req) begin
                    state_next = S_IDLE;
                end else if (ar2dfu_grant) begin
                    state_next = S_OWN;
                end
            end
            S_OWN: begin
                if (!owner_req) begin
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Owner selection, round-robin history, AR wait counter and sticky timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_owner   <= 1'b0;
            last_owner  <= 1'b1;
            wait_cnt    <= '0;
            arb_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    wait_cnt <= '0;
                    if (any_req) begin
                        arb_owner <= sel_owner;
                    end
                end
                S_REQ: begin
                    if (owner_req && !ar2dfu_grant && (wait_cnt != CNT_MAX)) begin
                        wait_cnt <= cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            arb_timeout <= 1'b1;
                        end
                    end
                end
                S_OWN: begin
                    if (!owner_req) begin
                        last_owner <= arb_owner;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Channel outputs: request in REQ/OWN, owner's signals forwarded only in OWN.
    always_comb begin
        ld_grant            = 1'b0;
        st_grant            = 1'b0;
        dfu2ar_grant_req    = 1'b0;
        dfu2ar_wr_req       = 1'b0;
        dfu2ar_addr         = '0;
        dfu2ar_addr_vld     = 1'b0;
        dfu2ar_data_out     = '0;
        dfu2ar_data_out_vld = 1'b0;
        case (state)
            S_REQ: begin
                dfu2ar_grant_req = 1'b1;
            end
            S_OWN: begin
                dfu2ar_grant_req = 1'b1;
                if (arb_owner) begin
                    st_grant            = 1'b1;
                    dfu2ar_wr_req       = st_rd_req;
                    dfu2ar_addr         = st_addr;
                    dfu2ar_addr_vld     = st_addr_vld;
                    dfu2ar_data_out     = st_data_out;
                    dfu2ar_data_out_vld = st_data_out_vld;
                end else begin
                    ld_grant            = 1'b1;
                    dfu2ar_wr_req       = ld_wr_req;
                    dfu2ar_addr         = ld_addr;
                    dfu2ar_addr_vld     = ld_addr_vld;
                    dfu2ar_data_out     = ld_data_out;
                    dfu2ar_data_out_vld = ld_data_out_vld;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dfu_ar_arbiter.sv
// tb_dfu_ar_arbiter: directed scenarios for the DFU/AR channel arbiter.
module tb_dfu_ar_arbiter;

    localparam int FW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk;
    logic          rst;
    logic          ld_grant_req;
    logic          ld_wr_req;
    logic [FW-1:0] ld_addr;
    logic          ld_addr_vld;
    logic [DW-1:0] ld_data_out;
    logic          ld_data_out_vld;
    logic          ld_grant;
    logic          st_grant_req;
    logic          st_rd_req;
    logic [FW-1:0] st_addr;
    logic          st_addr_vld;
    logic [DW-1:0] st_data_out;
    logic          st_data_out_vld;
    logic          st_grant;
    logic          dfu2ar_grant_req;
    logic          ar2dfu_grant;
    logic          dfu2ar_wr_req;
    logic [FW-1:0] dfu2ar_addr;
    logic          dfu2ar_addr_vld;
    logic [DW-1:0] dfu2ar_data_out;
    logic          dfu2ar_data_out_vld;
    logic          arb_owner;
    logic          arb_busy;
    logic          arb_timeout;
    logic [69:0]   fwd;

    int total = 0;
    int bad   = 0;

    dfu_ar_arbiter #(
        .FIFO_WIDTH (FW),
        .DATA_WIDTH (DW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .ld_grant_req       (ld_grant_req),
        .ld_wr_req          (ld_wr_req),
        .ld_addr            (ld_addr),
        .ld_addr_vld        (ld_addr_vld),
        .ld_data_out        (ld_data_out),
        .ld_data_out_vld    (ld_data_out_vld),
        .ld_grant           (ld_grant),
        .st_grant_req       (st_grant_req),
        .st_rd_req          (st_rd_req),
        .st_addr            (st_addr),
        .st_addr_vld        (st_addr_vld),
        .st_data_out        (st_data_out),
        .st_data_out_vld    (st_data_out_vld),
        .st_grant           (st_grant),
        .dfu2ar_grant_req   (dfu2ar_grant_req),
        .ar2dfu_grant       (ar2dfu_grant),
        .dfu2ar_wr_req      (dfu2ar_wr_req),
        .dfu2ar_addr        (dfu2ar_addr),
        .dfu2ar_addr_vld    (dfu2ar_addr_vld),
        .dfu2ar_data_out    (dfu2ar_data_out),
        .dfu2ar_data_out_vld(dfu2ar_data_out_vld),
        .arb_owner          (arb_owner),
        .arb_busy           (arb_busy),
        .arb_timeout        (arb_timeout)
    );

    // Every channel-side output and both grants, for all-zero checks.
    assign fwd = {ld_grant, st_grant, dfu2ar_grant_req, dfu2ar_wr_req,
                  dfu2ar_addr_vld, dfu2ar_data_out_vld, dfu2ar_addr, dfu2ar_data_out};

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute bound on the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Grant the pending request, then release it from the owner side and
    // walk through GAP; returns at the start of the following IDLE cycle.
    task automatic grant_and_release(input bit who);
        ar2dfu_grant = 1'b1;
        tick();
        ar2dfu_grant = 1'b0;
        if (who) st_grant_req = 1'b0;
        else     ld_grant_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ld_grant_req = 1'b0; ld_wr_req = 1'b0; ld_addr = '0; ld_addr_vld = 1'b0;
        ld_data_out = '0; ld_data_out_vld = 1'b0;
        st_grant_req = 1'b0; st_rd_req = 1'b0; st_addr = '0; st_addr_vld = 1'b0;
        st_data_out = '0; st_data_out_vld = 1'b0;
        ar2dfu_grant = 1'b0;
        #3;
        total++; if (fwd !== 70'd0) begin bad++; $display("[TB] FAIL reset_fwd: got %h want 0", fwd); end
        total++; if (arb_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", arb_busy); end
        total++; if (arb_owner !== 1'b0) begin bad++; $display("[TB] FAIL reset_owner: got %b want 0", arb_owner); end
        total++; if (arb_timeout !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout: got %b want 0", arb_timeout); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        total++; if (arb_busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_no_req_busy: got %b want 0", arb_busy); end
    endtask

    task automatic test_load_only();
        tick();
        ld_grant_req = 1'b1;
        ld_wr_req    = 1'b1;
        @(negedge clk);
        total++; if (dfu2ar_grant_req !== 1'b0) begin bad++; $display("[TB] FAIL ld_c2_req: got %b want 0", dfu2ar_grant_req); end
        for (int c = 3; c <= 9; c++) begin
            tick();
            if (c == 4) begin ld_addr = 32'h0FF; ld_addr_vld = 1'b1; end
            if (c == 5) ar2dfu_grant = 1'b1;
            if (c == 6) ar2dfu_grant = 1'b0;
            if (c == 7) begin
                ld_addr = 32'h100; ld_addr_vld = 1'b1;
                ld_data_out = 32'hDEAD_BEEF; ld_data_out_vld = 1'b1;
                st_addr = 32'h2A0; st_addr_vld = 1'b1;
            end
            if (c == 8) begin ld_addr_vld = 1'b0; ld_data_out_vld = 1'b0; st_addr_vld = 1'b0; end
            if (c == 9) ld_grant_req = 1'b0;
            @(negedge clk);
            total++; if (dfu2ar_grant_req !== 1'b1) begin bad++; $display("[TB] FAIL ld_req_c%0d: got %b want 1", c, dfu2ar_grant_req); end
            total++; if (ld_grant !== (c >= 6)) begin bad++; $display("[TB] FAIL ld_grant_c%0d: got %b want %b", c, ld_grant, (c >= 6)); end
            total++; if (st_grant !== 1'b0) begin bad++; $display("[TB] FAIL ld_stgrant_c%0d: got %b want 0", c, st_grant); end
            if (c == 4) begin
                total++; if ({dfu2ar_wr_req, dfu2ar_addr_vld, dfu2ar_addr} !== 34'd0) begin bad++; $display("[TB] FAIL ld_req_masked: got %b %b %h want 0 0 0", dfu2ar_wr_req, dfu2ar_addr_vld, dfu2ar_addr); end
            end
            if (c == 7) begin
                total++; if (dfu2ar_addr !== 32'h100) begin bad++; $display("[TB] FAIL ld_addr_c7: got %h want 100", dfu2ar_addr); end
                total++; if (dfu2ar_addr_vld !== 1'b1) begin bad++; $display("[TB] FAIL ld_addr_vld_c7: got %b want 1", dfu2ar_addr_vld); end
                total++; if (dfu2ar_data_out !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL ld_data_c7: got %h want deadbeef", dfu2ar_data_out); end
                total++; if (dfu2ar_wr_req !== 1'b1) begin bad++; $display("[TB] FAIL ld_wr_c7: got %b want 1", dfu2ar_wr_req); end
            end
        end
        tick();
        @(negedge clk);
        total++; if (fwd !== 70'd0) begin bad++; $display("[TB] FAIL ld_gap_zero: got %h want 0", fwd); end
        total++; if (arb_busy !== 1'b1) begin bad++; $display("[TB] FAIL ld_gap_busy: got %b want 1", arb_busy); end
        tick();
        @(negedge clk);
        total++; if (arb_busy !== 1'b0) begin bad++; $display("[TB] FAIL ld_c11_busy: got %b want 0", arb_busy); end
        ld_wr_req = 1'b0;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        ld_grant_req = 1'b1; st_grant_req = 1'b1;
        ld_wr_req = 1'b0; ld_addr = 32'h1C0; ld_addr_vld = 1'b1;
        st_rd_req = 1'b1; st_addr = 32'h2B0; st_addr_vld = 1'b1;
        tick();
        @(negedge clk);
        total++; if (arb_owner !== 1'b0) begin bad++; $display("[TB] FAIL sim_owner_ld: got %b want 0", arb_owner); end
        total++; if (st_grant !== 1'b0) begin bad++; $display("[TB] FAIL sim_req_stgrant: got %b want 0", st_grant); end
        ar2dfu_grant = 1'b1;
        tick();
        ar2dfu_grant = 1'b0;
        @(negedge clk);
        total++; if ({ld_grant, st_grant} !== 2'b10) begin bad++; $display("[TB] FAIL sim_ld_own: got %b want 10", {ld_grant, st_grant}); end
        total++; if ({dfu2ar_wr_req, dfu2ar_addr} !== {1'b0, 32'h1C0}) begin bad++; $display("[TB] FAIL sim_ld_fwd: got %b %h want 0 1c0", dfu2ar_wr_req, dfu2ar_addr); end
        ld_grant_req = 1'b0;
        tick();
        @(negedge clk);
        total++; if (fwd !== 70'd0) begin bad++; $display("[TB] FAIL sim_gap_zero: got %h want 0", fwd); end
        tick();
        @(negedge clk);
        total++; if (arb_busy !== 1'b0) begin bad++; $display("[TB] FAIL sim_idle_busy: got %b want 0", arb_busy); end
        tick();
        @(negedge clk);
        total++; if ({arb_owner, dfu2ar_grant_req, st_grant} !== 3'b110) begin bad++; $display("[TB] FAIL sim_st_req: got %b want 110", {arb_owner, dfu2ar_grant_req, st_grant}); end
        ar2dfu_grant = 1'b1;
        tick();
        ar2dfu_grant = 1'b0;
        @(negedge clk);
        total++; if ({ld_grant, st_grant} !== 2'b01) begin bad++; $display("[TB] FAIL sim_st_own: got %b want 01", {ld_grant, st_grant}); end
        total++; if ({dfu2ar_wr_req, dfu2ar_addr_vld, dfu2ar_addr} !== {2'b11, 32'h2B0}) begin bad++; $display("[TB] FAIL sim_st_fwd: got %b %b %h want 1 1 2b0", dfu2ar_wr_req, dfu2ar_addr_vld, dfu2ar_addr); end
        st_grant_req = 1'b0;
        tick();
        tick();
        ld_addr_vld = 1'b0; st_addr_vld = 1'b0; st_rd_req = 1'b0;
    endtask

    task automatic test_round_robin();
        ld_grant_req = 1'b1; st_grant_req = 1'b1;
        tick();
        @(negedge clk);
        total++; if (arb_owner !== 1'b0) begin bad++; $display("[TB] FAIL rr_after_st: got %b want 0", arb_owner); end
        ar2dfu_grant = 1'b1;
        tick();
        ar2dfu_grant = 1'b0;
        @(negedge clk);
        total++; if ({ld_grant, st_grant} !== 2'b10) begin bad++; $display("[TB] FAIL rr_ld_own: got %b want 10", {ld_grant, st_grant}); end
        ld_grant_req = 1'b0;
        tick();
        ld_grant_req = 1'b1;
        tick();
        tick();
        @(negedge clk);
        total++; if (arb_owner !== 1'b1) begin bad++; $display("[TB] FAIL rr_after_ld: got %b want 1", arb_owner); end
        ar2dfu_grant = 1'b1;
        tick();
        ar2dfu_grant = 1'b0;
        @(negedge clk);
        total++; if ({ld_grant, st_grant} !== 2'b01) begin bad++; $display("[TB] FAIL rr_st_own: got %b want 01", {ld_grant, st_grant}); end
        ld_grant_req = 1'b0; st_grant_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_abandon();
        ld_grant_req = 1'b1;
        tick();
        grant_and_release(1'b0);
        st_grant_req = 1'b1;
        tick();
        @(negedge clk);
        total++; if ({arb_owner, dfu2ar_grant_req, st_grant} !== 3'b110) begin bad++; $display("[TB] FAIL ab_req: got %b want 110", {arb_owner, dfu2ar_grant_req, st_grant}); end
        st_grant_req = 1'b0;
        tick();
        @(negedge clk);
        total++; if ({arb_busy, dfu2ar_grant_req, st_grant} !== 3'b000) begin bad++; $display("[TB] FAIL ab_idle: got %b want 000", {arb_busy, dfu2ar_grant_req, st_grant}); end
        ld_grant_req = 1'b1; st_grant_req = 1'b1;
        tick();
        @(negedge clk);
        total++; if (arb_owner !== 1'b1) begin bad++; $display("[TB] FAIL ab_last_kept: got %b want 1", arb_owner); end
        ar2dfu_grant = 1'b1;
        tick();
        ar2dfu_grant = 1'b0;
        @(negedge clk);
        total++; if ({ld_grant, st_grant} !== 2'b01) begin bad++; $display("[TB] FAIL ab_st_own: got %b want 01", {ld_grant, st_grant}); end
        ld_grant_req = 1'b0; st_grant_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        @(negedge clk);
        total++; if (arb_timeout !== 1'b0) begin bad++; $display("[TB] FAIL to_initial: got %b want 0", arb_timeout); end
        ld_grant_req = 1'b1;
        tick();
        for (int k = 1; k <= TO - 1; k++) tick();
        @(negedge clk);
        total++; if (arb_timeout !== 1'b0) begin bad++; $display("[TB] FAIL to_early: got %b want 0", arb_timeout); end
        tick();
        @(negedge clk);
        total++; if (arb_timeout !== 1'b1) begin bad++; $display("[TB] FAIL to_set: got %b want 1", arb_timeout); end
        for (int k = 0; k < 3; k++) tick();
        @(negedge clk);
        total++; if ({arb_timeout, dfu2ar_grant_req, ld_grant, arb_busy} !== 4'b1101) begin bad++; $display("[TB] FAIL to_waiting: got %b want 1101", {arb_timeout, dfu2ar_grant_req, ld_grant, arb_busy}); end
        ar2dfu_grant = 1'b1;
        tick();
        ar2dfu_grant = 1'b0;
        @(negedge clk);
        total++; if (ld_grant !== 1'b1) begin bad++; $display("[TB] FAIL to_late_grant: got %b want 1", ld_grant); end
        ld_grant_req = 1'b0;
        tick();
        tick();
        @(negedge clk);
        total++; if ({arb_timeout, arb_busy} !== 2'b10) begin bad++; $display("[TB] FAIL to_sticky: got %b want 10", {arb_timeout, arb_busy}); end
    endtask

    task automatic test_reset_mid_own();
        ld_grant_req = 1'b1;
        tick();
        grant_and_release(1'b0);
        ld_grant_req = 1'b1; ld_addr = 32'h300; ld_addr_vld = 1'b1;
        ld_data_out = 32'hCAFE_F00D; ld_data_out_vld = 1'b1;
        tick();
        ar2dfu_grant = 1'b1;
        tick();
        ar2dfu_grant = 1'b0;
        @(negedge clk);
        total++; if ({dfu2ar_data_out_vld, dfu2ar_data_out} !== {1'b1, 32'hCAFE_F00D}) begin bad++; $display("[TB] FAIL rm_fwd: got %b %h want 1 cafef00d", dfu2ar_data_out_vld, dfu2ar_data_out); end
        tick();
        rst = 1'b1;
        #1;
        total++; if (fwd !== 70'd0) begin bad++; $display("[TB] FAIL rm_async_zero: got %h want 0", fwd); end
        total++; if ({arb_busy, arb_owner, arb_timeout} !== 3'b000) begin bad++; $display("[TB] FAIL rm_async_status: got %b want 000", {arb_busy, arb_owner, arb_timeout}); end
        tick();
        rst = 1'b0;
        st_grant_req = 1'b1;
        tick();
        @(negedge clk);
        total++; if ({arb_owner, dfu2ar_grant_req, ld_grant} !== 3'b010) begin bad++; $display("[TB] FAIL rm_next_ld: got %b want 010", {arb_owner, dfu2ar_grant_req, ld_grant}); end
        ld_grant_req = 1'b0; st_grant_req = 1'b0;
        ld_addr_vld = 1'b0; ld_data_out_vld = 1'b0;
        tick();
        @(negedge clk);
        total++; if (arb_busy !== 1'b0) begin bad++; $display("[TB] FAIL rm_final_idle: got %b want 0", arb_busy); end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_load_only();
        test_simultaneous();
        test_round_robin();
        test_abandon();
        test_timeout();
        test_reset_mid_own();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
